core_bus_arbiter: RTL and testbench
===================================

# core_bus_arbiter

Two-master to one-slave Avalon-MM arbiter that lets the core's instruction bus and data bus share a single memory/interconnect port. It sits between the core's ibus/dbus request/response pairs and a single pipelined Avalon slave with `readdatavalid`. The core-facing ports keep waitrequest-only semantics: read data is valid in the cycle `waitrequest` drops. Arbitration is round-robin between masters, with at most one outstanding transaction at a time, plus a read-response timeout.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width; byteenable width is DW/8
- `TIMEOUT`, 255, maximum cycles to wait for `s_readdatavalid` after read acceptance; must be ≥1
- `clk`  in  1  clock, all logic rising-edge
- `rst`  in  1  reset, asynchronous, active-low
- `ibus_read` / `ibus_write`  in  1  instruction-master request
- `ibus_address`  in  AW
- `ibus_writedata`  in  DW
- `ibus_byteenable`  in  DW/8
- `ibus_readdata`  out  DW
- `ibus_waitrequest`  out  1
- `dbus_read` / `dbus_write` / `dbus_address` / `dbus_writedata` / `dbus_byteenable` / `dbus_readdata` / `dbus_waitrequest`: same widths and meaning for the data master
- `s_read` / `s_write`  out  1  slave request
- `s_address`  out  AW
- `s_writedata`  out  DW
- `s_byteenable`  out  DW/8
- `s_waitrequest`  in  1  slave not accepting
- `s_readdata`  in  DW
- `s_readdatavalid`  in  1  read response strobe
- `timeout_err`  out  1  one-cycle pulse when a read timed out

## Operation
- **States:**
  - IDLE: no grant.
  - GRANT: a master owns the slave and a request is being presented.
  - RDWAIT: a read was accepted and the response is pending.
- **Arbitration:** happens only in IDLE, or on the cycle a transaction completes. A master is requesting when `read|write` is high.
  - Only one master requesting: grant it.
  - Both requesting: grant the master not granted last. The `last_grant` register resets to ibus, so dbus wins the first tie.
  - A requesting master with `read` and `write` both high is treated as a write. The bench must never drive this case.
- **GRANT state:**
  - `s_*` outputs mirror the owner's request combinationally; the non-owner sees `waitrequest=1`.
  - Write accepted (`s_waitrequest=0`): the owner's `waitrequest` drops the same cycle; the write completes.
  - Read accepted: `s_read` drops the next cycle and the state goes to RDWAIT. The owner's `waitrequest` stays 1.
- **RDWAIT state:**
  - All `s_*` requests are 0.
  - On `s_readdatavalid`: the owner's `readdata = s_readdata` and its `waitrequest=0` in that cycle; the read completes.
  - `s_readdatavalid` outside RDWAIT is ignored.
- **Timeout:** an 8-bit-or-wider counter clears on read acceptance and increments each RDWAIT cycle. If it reaches `TIMEOUT` without a response:
  - the owner gets `readdata = 32'hDEAD_BEEF` (truncated/extended to DW) and `waitrequest=0`;
  - `timeout_err` pulses;
  - the state returns to IDLE;
  - a later stray `s_readdatavalid` is ignored.
- **Completion:** updates `last_grant` to the owner. A new grant may be issued in the completion cycle's next state, so back-to-back transactions have no idle bubble.
- **Ownership:** once granted, ownership is not revoked until completion. Master requests are not required to stay stable, but the core holds them while `waitrequest` is high.
- **Non-owner read data:** `ibus_readdata` / `dbus_readdata` are 0 whenever that master is not receiving read data.

## Timing
- **Reset (`rst=0`, async):**
  - state = IDLE, `last_grant` = ibus, counter = 0;
  - all `s_*` outputs 0;
  - both `waitrequest` = 1;
  - both `readdata` = 0;
  - `timeout_err` = 0.
- **Reset release:** outputs stay as above until the first rising edge after release.
- **IDLE → GRANT:** one cycle (registered grant). A request seen in cycle N is presented on `s_*` in cycle N+1.
- **Write latency:** 1 + slave wait cycles to master `waitrequest=0`.
- **Read latency:** 1 (grant) + slave wait cycles + 1 (accept registered) + slave read latency.
- **Reset mid-transaction:** abandons it immediately; a late response is ignored.
- **Simultaneous completion and new requests:** the tie rule uses the already-updated `last_grant`.

## Test plan
- **Single write:** dbus write addr 0x100, data 0xA5A5A5A5, be 0xF, slave `waitrequest` low → `s_write` at cycle+1 with identical fields; `dbus_waitrequest` low that cycle; ibus stays waitrequest=1.
- **Single read:** ibus read 0x0, slave accepts immediately and returns 0x00000013 with latency 2 → `ibus_readdata` = 0x13 and `ibus_waitrequest` low exactly in the `readdatavalid` cycle.
- **Contention:** both masters read continuously → grants alternate dbus, ibus, dbus, ibus. No `s_read` is overlapped or dropped, and each master gets its own data.
- **Slave backpressure:** `s_waitrequest` held high 5 cycles during a dbus write → `s_*` stable for all 5 cycles; ibus request is not granted until completion.
- **Timeout (TIMEOUT=4):** read accepted, no `readdatavalid` → after 4 RDWAIT cycles the owner gets 0xDEADBEEF and `timeout_err` pulses once; a `readdatavalid` injected 2 cycles later causes no master response.
- **Async reset mid-read:** `rst` low during RDWAIT → all outputs return to reset values without a clock edge; the first request after release is granted normally.

Source files
------------

// File: rtl/core_bus_arbiter.sv
// ============================================================================
//  Module      : core_bus_arbiter
//  Description : Round-robin arbiter that lets the instruction and data
//                masters (waitrequest-only) share one pipelined Avalon-MM
//                slave that uses readdatavalid. It allows one outstanding
//                transaction and applies a timeout to read responses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  // instruction master
  input  logic            ibus_read_i,
  input  logic            ibus_write_i,
  input  logic [AW-1:0]   ibus_address_i,
  input  logic [DW-1:0]   ibus_writedata_i,
  input  logic [DW/8-1:0] ibus_byteenable_i,
  output logic [DW-1:0]   ibus_readdata_o,
  output logic            ibus_waitrequest_o,
  // data master
  input  logic            dbus_read_i,
  input  logic            dbus_write_i,
  input  logic [AW-1:0]   dbus_address_i,
  input  logic [DW-1:0]   dbus_writedata_i,
  input  logic [DW/8-1:0] dbus_byteenable_i,
  output logic [DW-1:0]   dbus_readdata_o,
  output logic            dbus_waitrequest_o,
  // shared slave
  output logic            s_read_o,
  output logic            s_write_o,
  output logic [AW-1:0]   s_address_o,
  output logic [DW-1:0]   s_writedata_o,
  output logic [DW/8-1:0] s_byteenable_o,
  input  logic            s_waitrequest_i,
  input  logic [DW-1:0]   s_readdata_i,
  input  logic            s_readdatavalid_i,
  output logic            timeout_err_o
);

  // Counter is at least 8 bits and always wide enough to hold TIMEOUT.
  localparam int              CW          = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0]   C_TO_COUNT  = CW'(TIMEOUT);
  localparam logic [DW-1:0]   C_TO_DATA   = DW'(32'hDEAD_BEEF);
  localparam logic            C_M_IBUS    = 1'b0;
  localparam logic            C_M_DBUS    = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_RDWAIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q,  last_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  logic            ireq, dreq, any_req;
  logic            own_rd, own_wr, own_req;
  logic [AW-1:0]   own_addr;
  logic [DW-1:0]   own_wdata;
  logic [DW/8-1:0] own_be;
  logic [CW-1:0]   cnt_inc;

  // Combinational response for whichever master currently owns the slave.
  logic            own_wait;
  logic [DW-1:0]   own_rdata;
  logic            done;

  // On a tie the master that was not granted last wins; otherwise the sole requester wins.
  function automatic logic pick(input logic i_req, input logic d_req, input logic last);
    if (i_req && d_req) return ~last;
    return d_req;
  endfunction

  assign ireq    = ibus_read_i | ibus_write_i;
  assign dreq    = dbus_read_i | dbus_write_i;
  assign any_req = ireq | dreq;

  assign own_rd    = (owner_q == C_M_DBUS) ? dbus_read_i       : ibus_read_i;
  assign own_wr    = (owner_q == C_M_DBUS) ? dbus_write_i      : ibus_write_i;
  assign own_addr  = (owner_q == C_M_DBUS) ? dbus_address_i    : ibus_address_i;
  assign own_wdata = (owner_q == C_M_DBUS) ? dbus_writedata_i  : ibus_writedata_i;
  assign own_be    = (owner_q == C_M_DBUS) ? dbus_byteenable_i : ibus_byteenable_i;
  assign own_req   = own_rd | own_wr;
  assign cnt_inc   = cnt_q + CW'(1);

  // Next-state, slave request mirroring and owner response generation.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    s_read_o       = 1'b0;
    s_write_o      = 1'b0;
    s_address_o    = '0;
    s_writedata_o  = '0;
    s_byteenable_o = '0;
    timeout_err_o  = 1'b0;
    own_wait       = 1'b1;
    own_rdata      = '0;
    done           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_GRANT;
          owner_d = pick(ireq, dreq, last_q);
        end
      end

      ST_GRANT: begin
        // Read+write together is treated as a write.
        s_write_o      = own_wr;
        s_read_o       = own_rd & ~own_wr;
        s_address_o    = own_addr;
        s_writedata_o  = own_wdata;
        s_byteenable_o = own_be;
        if (!own_req) begin
          // Owner withdrew before being served: release the grant.
          state_d = ST_IDLE;
        end else if (!s_waitrequest_i) begin
          if (own_wr) begin
            own_wait = 1'b0;
            done     = 1'b1;
          end else begin
            state_d = ST_RDWAIT;
            cnt_d   = '0;
          end
        end
      end

      ST_RDWAIT: begin
        if (s_readdatavalid_i) begin
          own_wait  = 1'b0;
          own_rdata = s_readdata_i;
          done      = 1'b1;
        end else if (cnt_inc == C_TO_COUNT) begin
          own_wait      = 1'b0;
          own_rdata     = C_TO_DATA;
          timeout_err_o = 1'b1;
          done          = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Completion re-arbitrates at once, using the owner as the new last grant.
    if (done) begin
      last_d = owner_q;
      if (any_req) begin
        state_d = ST_GRANT;
        owner_d = pick(ireq, dreq, owner_q);
      end else begin
        state_d = ST_IDLE;
      end
    end

    ibus_waitrequest_o = 1'b1;
    dbus_waitrequest_o = 1'b1;
    ibus_readdata_o    = '0;
    dbus_readdata_o    = '0;
    if (owner_q == C_M_DBUS) begin
      dbus_waitrequest_o = own_wait;
      dbus_readdata_o    = own_rdata;
    end else begin
      ibus_waitrequest_o = own_wait;
      ibus_readdata_o    = own_rdata;
    end
  end

  // State, ownership, round-robin history and timeout counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      owner_q <= C_M_IBUS;
      last_q  <= C_M_IBUS;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_core_bus_arbiter.sv
// ============================================================================
//  Module      : tb_core_bus_arbiter
//  Description : Directed self-checking bench for core_bus_arbiter with a
//                response scoreboard and an optional auto-responding slave.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ibus_read, ibus_write, dbus_read, dbus_write;
  logic [AW-1:0] ibus_address, dbus_address, s_address;
  logic [DW-1:0] ibus_writedata, dbus_writedata, ibus_readdata, dbus_readdata;
  logic [BW-1:0] ibus_byteenable, dbus_byteenable, s_byteenable;
  logic          ibus_waitrequest, dbus_waitrequest;
  logic          s_read, s_write, s_waitrequest, s_readdatavalid, timeout_err;
  logic [DW-1:0] s_writedata, s_readdata, m_rdata;
  logic          m_valid, auto_en;
  logic          a_valid = 1'b0, a_pend = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_data = '0;

  typedef struct packed {
    logic          master;
    logic [DW-1:0] data;
    logic          to;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   acc_reads = 0;

  always #5 clk = ~clk;

  assign s_readdatavalid = auto_en ? a_valid : m_valid;
  assign s_readdata      = auto_en ? a_data  : m_rdata;

  core_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .ibus_read_i        (ibus_read),
    .ibus_write_i       (ibus_write),
    .ibus_address_i     (ibus_address),
    .ibus_writedata_i   (ibus_writedata),
    .ibus_byteenable_i  (ibus_byteenable),
    .ibus_readdata_o    (ibus_readdata),
    .ibus_waitrequest_o (ibus_waitrequest),
    .dbus_read_i        (dbus_read),
    .dbus_write_i       (dbus_write),
    .dbus_address_i     (dbus_address),
    .dbus_writedata_i   (dbus_writedata),
    .dbus_byteenable_i  (dbus_byteenable),
    .dbus_readdata_o    (dbus_readdata),
    .dbus_waitrequest_o (dbus_waitrequest),
    .s_read_o           (s_read),
    .s_write_o          (s_write),
    .s_address_o        (s_address),
    .s_writedata_o      (s_writedata),
    .s_byteenable_o     (s_byteenable),
    .s_waitrequest_i    (s_waitrequest),
    .s_readdata_i       (s_readdata),
    .s_readdatavalid_i  (s_readdatavalid),
    .timeout_err_o      (timeout_err)
  );

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endfunction

  function automatic void push(input logic m, input logic [DW-1:0] d, input logic t);
    exp_t e;
    e.master = m;
    e.data   = d;
    e.to     = t;
    sb.push_back(e);
  endfunction

  // Auto slave: accepts immediately, answers one cycle after acceptance.
  always @(negedge clk) begin
    a_pend = s_read & ~s_waitrequest;
    a_addr = s_address;
  end

  always @(posedge clk) begin
    #1;
    a_valid = auto_en & a_pend;
    a_data  = a_addr ^ 32'h1357_0000;
  end

  // Response monitor: every master completion must match the scoreboard head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (s_read && !s_waitrequest) acc_reads++;
      if (!ibus_waitrequest || !dbus_waitrequest) begin
        if (sb.size() == 0) begin
          chk("unexpected_response", {ibus_waitrequest, dbus_waitrequest}, 2'b11);
        end else begin
          e = sb.pop_front();
          chk("rsp_master", {~ibus_waitrequest, ~dbus_waitrequest}, e.master ? 2'b01 : 2'b10);
          chk("rsp_data", e.master ? dbus_readdata : ibus_readdata, e.data);
          chk("rsp_timeout_err", timeout_err, e.to);
        end
      end else begin
        chk("idle_timeout_err", timeout_err, 0);
      end
      if (ibus_waitrequest) chk("ibus_rdata_zero", ibus_readdata, 0);
      if (dbus_waitrequest) chk("dbus_rdata_zero", dbus_readdata, 0);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_read"}, s_read, 0);
    chk({tag, "_s_write"}, s_write, 0);
    chk({tag, "_s_address"}, s_address, 0);
    chk({tag, "_s_writedata"}, s_writedata, 0);
    chk({tag, "_s_byteenable"}, s_byteenable, 0);
    chk({tag, "_ibus_wait"}, ibus_waitrequest, 1);
    chk({tag, "_dbus_wait"}, dbus_waitrequest, 1);
    chk({tag, "_ibus_rdata"}, ibus_readdata, 0);
    chk({tag, "_dbus_rdata"}, dbus_readdata, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    int k;
    ibus_read = 0; ibus_write = 0; ibus_address = '0; ibus_writedata = '0; ibus_byteenable = '0;
    dbus_read = 0; dbus_write = 0; dbus_address = '0; dbus_writedata = '0; dbus_byteenable = '0;
    s_waitrequest = 0; m_valid = 0; m_rdata = '0; auto_en = 0;

    // Reset
    #1 rst_n = 0;
    #1 chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1 chk_reset_outputs("release");
    nxt(); nxt();

    // Single write from dbus
    dbus_write = 1; dbus_address = 32'h100; dbus_writedata = 32'hA5A5_A5A5; dbus_byteenable = 4'hF;
    push(1'b1, '0, 1'b0);
    @(negedge clk);
    chk("wr_idle_s_write", s_write, 0);
    chk("wr_idle_dbus_wait", dbus_waitrequest, 1);
    nxt(); @(negedge clk);
    chk("wr_s_write", s_write, 1);
    chk("wr_s_read", s_read, 0);
    chk("wr_s_address", s_address, 32'h100);
    chk("wr_s_writedata", s_writedata, 32'hA5A5_A5A5);
    chk("wr_s_byteenable", s_byteenable, 4'hF);
    chk("wr_dbus_wait", dbus_waitrequest, 0);
    chk("wr_ibus_wait", ibus_waitrequest, 1);
    nxt();
    dbus_write = 0; dbus_address = '0; dbus_writedata = '0; dbus_byteenable = '0;
    nxt(); nxt();

    // Single read from ibus, slave latency 2
    ibus_read = 1; ibus_address = 32'h0;
    push(1'b0, 32'h13, 1'b0);
    nxt(); @(negedge clk);
    chk("rd_s_read", s_read, 1);
    chk("rd_s_address", s_address, 0);
    chk("rd_ibus_wait_grant", ibus_waitrequest, 1);
    nxt(); @(negedge clk);
    chk("rd_rdwait_s_read", s_read, 0);
    chk("rd_rdwait_ibus_wait", ibus_waitrequest, 1);
    nxt();
    m_valid = 1; m_rdata = 32'h13;
    @(negedge clk);
    chk("rd_valid_ibus_wait", ibus_waitrequest, 0);
    nxt();
    m_valid = 0; m_rdata = '0; ibus_read = 0;
    nxt(); nxt();

    // Contention: both read continuously, expect dbus, ibus, dbus, ibus
    auto_en = 1; acc_reads = 0;
    ibus_read = 1; ibus_address = 32'h40;
    dbus_read = 1; dbus_address = 32'h80;
    push(1'b1, 32'h1357_0080, 1'b0);
    push(1'b0, 32'h1357_0040, 1'b0);
    push(1'b1, 32'h1357_0080, 1'b0);
    push(1'b0, 32'h1357_0040, 1'b0);
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      nxt();
      k++;
    end
    chk("contention_pending", sb.size(), 0);
    sb.delete();
    ibus_read = 0; dbus_read = 0;
    chk("contention_accepts", acc_reads, 4);
    nxt(); nxt();
    auto_en = 0;
    nxt();

    // Slave backpressure on dbus write while ibus also writes
    s_waitrequest = 1;
    dbus_write = 1; dbus_address = 32'h200; dbus_writedata = 32'h1234_5678; dbus_byteenable = 4'h3;
    ibus_write = 1; ibus_address = 32'h300; ibus_writedata = 32'hCAFE_F00D; ibus_byteenable = 4'hC;
    push(1'b1, '0, 1'b0);
    push(1'b0, '0, 1'b0);
    nxt();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_s_write", s_write, 1);
      chk("bp_s_address", s_address, 32'h200);
      chk("bp_s_writedata", s_writedata, 32'h1234_5678);
      chk("bp_s_byteenable", s_byteenable, 4'h3);
      chk("bp_dbus_wait", dbus_waitrequest, 1);
      chk("bp_ibus_wait", ibus_waitrequest, 1);
      nxt();
    end
    s_waitrequest = 0;
    @(negedge clk);
    chk("bp_release_dbus_wait", dbus_waitrequest, 0);
    nxt();
    dbus_write = 0;
    @(negedge clk);
    chk("bp_ibus_s_address", s_address, 32'h300);
    chk("bp_ibus_s_writedata", s_writedata, 32'hCAFE_F00D);
    chk("bp_ibus_wait", ibus_waitrequest, 0);
    nxt();
    ibus_write = 0;
    nxt(); nxt();

    // Timeout on dbus read, then a stray late response
    dbus_read = 1; dbus_address = 32'h44;
    push(1'b1, 32'hDEAD_BEEF, 1'b1);
    nxt(); @(negedge clk);
    chk("to_s_read", s_read, 1);
    nxt(); @(negedge clk);
    chk("to_c2_dbus_wait", dbus_waitrequest, 1);
    chk("to_c2_timeout_err", timeout_err, 0);
    nxt(); nxt(); @(negedge clk);
    chk("to_c4_dbus_wait", dbus_waitrequest, 1);
    nxt(); @(negedge clk);
    chk("to_fire_timeout_err", timeout_err, 1);
    chk("to_fire_rdata", dbus_readdata, 32'hDEAD_BEEF);
    nxt();
    dbus_read = 0;
    nxt();
    m_valid = 1; m_rdata = 32'h99;
    @(negedge clk);
    chk("to_stray_dbus_wait", dbus_waitrequest, 1);
    chk("to_stray_dbus_rdata", dbus_readdata, 0);
    nxt();
    m_valid = 0; m_rdata = '0;
    nxt();

    // Asynchronous reset in the middle of a read
    ibus_read = 1; ibus_address = 32'h10;
    nxt(); nxt();
    @(negedge clk);
    #1 rst_n = 0;
    #1 chk_reset_outputs("async_rst");
    m_valid = 1; m_rdata = 32'h55;
    #1;
    chk("async_rst_late_ibus_wait", ibus_waitrequest, 1);
    chk("async_rst_late_ibus_rdata", ibus_readdata, 0);
    nxt();
    ibus_read = 0; m_valid = 0; m_rdata = '0;
    nxt();
    rst_n = 1;
    nxt();
    m_valid = 1; m_rdata = 32'h66;
    nxt();
    m_valid = 0; m_rdata = '0;

    // First requests after release: tie goes to dbus, then ibus
    dbus_write = 1; dbus_address = 32'h500; dbus_writedata = 32'h0BAD_F00D; dbus_byteenable = 4'hF;
    ibus_read = 1; ibus_address = 32'h20;
    push(1'b1, '0, 1'b0);
    push(1'b0, 32'h77, 1'b0);
    nxt(); @(negedge clk);
    chk("post_rst_s_write", s_write, 1);
    chk("post_rst_s_address", s_address, 32'h500);
    nxt();
    dbus_write = 0;
    @(negedge clk);
    chk("post_rst_s_read", s_read, 1);
    chk("post_rst_rd_address", s_address, 32'h20);
    nxt();
    m_valid = 1; m_rdata = 32'h77;
    nxt();
    ibus_read = 0; m_valid = 0; m_rdata = '0;
    nxt(); nxt();

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
